// File: rtl/stroke_sequencer_pkg.sv
// Shared definitions for the stroke sequencer: defaults shared with the
// tracker, the point record and the sequencer state encoding.
package stroke_sequencer_pkg;

  localparam int CW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [CW_DEF-1:0] x;
    logic [CW_DEF-1:0] y;
    logic              pen;
  } point_t;

  // Width of a flattened {x, y, pen} point for a given coordinate width.
  function automatic int point_width(input int cw);
    return 2 * cw + 1;
  endfunction

endpackage

// File: rtl/stroke_sequencer_point_fifo.sv
// Synchronous FIFO for tracked points. Head is valid whenever empty is low;
// pop and push in the same cycle leave the count unchanged.
module point_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stroke_sequencer.sv
// Turns a stream of pen points into line-engine requests, one at a time,
// with pen-up breaks, duplicate suppression and a hang watchdog.
module stroke_sequencer
  import stroke_sequencer_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = 600
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          point_valid,
  output logic          point_ready,
  input  logic [CW-1:0] point_x,
  input  logic [CW-1:0] point_y,
  input  logic          point_pen,
  output logic          line_start,
  output logic [CW-1:0] line_x0,
  output logic [CW-1:0] line_y0,
  output logic [CW-1:0] line_x1,
  output logic [CW-1:0] line_y1,
  input  logic          line_done,
  output logic          line_abort,
  output logic          busy,
  output logic          timeout_err,
  output seq_state_t    fsm_state
);

  localparam int PW   = point_width(CW);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  seq_state_t state, state_n;

  logic [PW-1:0]   fifo_head;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [CW-1:0]   head_x, head_y;
  logic            head_pen;

  logic [CW-1:0]   last_x, last_y;
  logic            last_valid;
  logic [WD_W-1:0] wdog;

  logic            load;
  logic [CW-1:0]   nx0, ny0, nx1, ny1;
  logic            clear_last, take_done, abort_now;

  // Handshake: a point transfers on the rising edge where point_valid and
  // point_ready are both high; point_ready depends only on the FIFO count.
  assign point_ready = !fifo_full;
  assign push        = point_valid && point_ready;

  point_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({point_x, point_y, point_pen}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign head_x   = fifo_head[PW-1 -: CW];
  assign head_y   = fifo_head[CW:1];
  assign head_pen = fifo_head[0];

  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign fsm_state = state;

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    load       = 1'b0;
    nx0        = line_x0;
    ny0        = line_y0;
    nx1        = line_x1;
    ny1        = line_y1;
    clear_last = 1'b0;
    take_done  = 1'b0;
    abort_now  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!head_pen) begin
            clear_last = 1'b1;
          end else if (!last_valid) begin
            load    = 1'b1;
            nx0     = head_x;
            ny0     = head_y;
            nx1     = head_x;
            ny1     = head_y;
            state_n = ST_ISSUE;
          end else if (head_x != last_x || head_y != last_y) begin
            load    = 1'b1;
            nx0     = last_x;
            ny0     = last_y;
            nx1     = head_x;
            ny1     = head_y;
            state_n = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the timeout cycle still counts as completion.
        if (line_done) begin
          take_done = 1'b1;
          state_n   = ST_IDLE;
        end else if (wdog == WD_LIMIT) begin
          abort_now = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      line_start  <= 1'b0;
      line_abort  <= 1'b0;
      timeout_err <= 1'b0;
      line_x0     <= '0;
      line_y0     <= '0;
      line_x1     <= '0;
      line_y1     <= '0;
      last_x      <= '0;
      last_y      <= '0;
      last_valid  <= 1'b0;
      wdog        <= '0;
    end else begin
      state       <= state_n;
      line_start  <= (state == ST_ISSUE);
      line_abort  <= abort_now;
      timeout_err <= abort_now;
      if (load) begin
        line_x0 <= nx0;
        line_y0 <= ny0;
        line_x1 <= nx1;
        line_y1 <= ny1;
      end
      if (state == ST_ISSUE) begin
        wdog <= '0;
      end else if (state == ST_WAIT && wdog != '1) begin
        wdog <= wdog + WD_W'(1);
      end
      if (clear_last || abort_now) begin
        last_valid <= 1'b0;
      end else if (take_done) begin
        last_x     <= line_x1;
        last_y     <= line_y1;
        last_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stroke_sequencer.sv
// Self-checking bench for stroke_sequencer: fixed vector table, hand-built
// corner sequences and a randomized stream against a point-stream model.
module tb_stroke_sequencer;
  import stroke_sequencer_pkg::*;

  localparam int CW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 600;
  localparam int OBS_N   = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          point_valid = 1'b0;
  logic          point_ready;
  logic [CW-1:0] point_x = '0;
  logic [CW-1:0] point_y = '0;
  logic          point_pen = 1'b0;
  logic          line_start;
  logic [CW-1:0] line_x0, line_y0, line_x1, line_y1;
  logic          line_done = 1'b0;
  logic          line_abort;
  logic          busy;
  logic          timeout_err;
  seq_state_t    fsm_state;

  stroke_sequencer #(
    .CW      (CW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .point_valid (point_valid),
    .point_ready (point_ready),
    .point_x     (point_x),
    .point_y     (point_y),
    .point_pen   (point_pen),
    .line_start  (line_start),
    .line_x0     (line_x0),
    .line_y0     (line_y0),
    .line_x1     (line_x1),
    .line_y1     (line_y1),
    .line_done   (line_done),
    .line_abort  (line_abort),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // engine model and request monitor, all on the falling edge
  bit                eng_hang = 1'b0;
  int                eng_delay = 3;
  int                inject_req = 0;
  int                inject_seen = 0;
  bit                eng_pend = 1'b0;
  int                eng_cnt = 0;
  logic [4*CW-1:0]   eng_hold = '0;
  logic [4*CW-1:0]   obs [OBS_N];
  int                start_cnt = 0;
  int                overlap_err = 0;
  int                stab_err = 0;
  logic [4*CW-1:0]   cur_line;

  assign cur_line = {line_x0, line_y0, line_x1, line_y1};

  always @(negedge clk) begin
    line_done = 1'b0;
    if (reset || line_abort) begin
      eng_pend = 1'b0;
    end else if (line_start) begin
      if (eng_pend) overlap_err++;
      if (start_cnt < OBS_N) obs[start_cnt] = cur_line;
      start_cnt++;
      eng_pend = 1'b1;
      eng_cnt  = eng_delay;
      eng_hold = cur_line;
    end else if (eng_pend) begin
      if (cur_line !== eng_hold) stab_err++;
      if (!eng_hang) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt <= 0) begin
          line_done = 1'b1;
          eng_pend  = 1'b0;
        end
      end
    end
    if (inject_seen != inject_req) begin
      line_done   = 1'b1;
      inject_seen = inject_req;
    end
  end

  // scoreboard: the expected request list follows from the point stream alone
  logic [4*CW-1:0] exp_q[$];
  bit              m_lv = 1'b0;
  logic [CW-1:0]   m_lx = '0;
  logic [CW-1:0]   m_ly = '0;
  int              rd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_point(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic pen);
    if (!pen) begin
      m_lv = 1'b0;
    end else if (!m_lv) begin
      exp_q.push_back({x, y, x, y});
      m_lv = 1'b1;
      m_lx = x;
      m_ly = y;
    end else if (x != m_lx || y != m_ly) begin
      exp_q.push_back({m_lx, m_ly, x, y});
      m_lx = x;
      m_ly = y;
    end
  endtask

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic send(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic pen);
    int guard = 0;
    point_x     = x;
    point_y     = y;
    point_pen   = pen;
    point_valid = 1'b1;
    while (!point_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!point_ready) begin
      check("push_accept", point_ready, 1);
      point_valid = 1'b0;
      return;
    end
    model_point(x, y, pen);
    @(negedge clk);
    point_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic drain();
    logic [4*CW-1:0] e;
    while (rd < start_cnt && rd < OBS_N) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_request: got %0h expected none", obs[rd]);
      end else begin
        e = exp_q.pop_front();
        check("request", obs[rd], e);
      end
      rd++;
    end
    check("requests_missing", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    point_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_lv = 1'b0;
    rd   = start_cnt;
  endtask

  typedef struct {
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            pen;
    int              exp_req;
    logic [4*CW-1:0] exp_line;
  } vec_t;

  vec_t tbl [12];

  initial begin : main
    int n;
    int m;
    tbl[0]  = '{8'd10,  8'd20,  1'b1, 1, {8'd10,  8'd20, 8'd10,  8'd20}};
    tbl[1]  = '{8'd30,  8'd25,  1'b1, 1, {8'd10,  8'd20, 8'd30,  8'd25}};
    tbl[2]  = '{8'd30,  8'd60,  1'b1, 1, {8'd30,  8'd25, 8'd30,  8'd60}};
    tbl[3]  = '{8'd30,  8'd60,  1'b1, 0, 32'h0};
    tbl[4]  = '{8'd9,   8'd9,   1'b0, 0, 32'h0};
    tbl[5]  = '{8'd40,  8'd40,  1'b1, 1, {8'd40,  8'd40, 8'd40,  8'd40}};
    tbl[6]  = '{8'd7,   8'd7,   1'b1, 1, {8'd40,  8'd40, 8'd7,   8'd7}};
    tbl[7]  = '{8'd7,   8'd7,   1'b1, 0, 32'h0};
    tbl[8]  = '{8'd255, 8'd0,   1'b1, 1, {8'd7,   8'd7,  8'd255, 8'd0}};
    tbl[9]  = '{8'd255, 8'd0,   1'b0, 0, 32'h0};
    tbl[10] = '{8'd255, 8'd0,   1'b1, 1, {8'd255, 8'd0,  8'd255, 8'd0}};
    tbl[11] = '{8'd0,   8'd255, 1'b1, 1, {8'd255, 8'd0,  8'd0,   8'd255}};

    // reset state
    do_reset();
    check("rst_line_start", line_start, 0);
    check("rst_line_abort", line_abort, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_point_ready", point_ready, 1);
    check("rst_coords", cur_line, 0);
    check("rst_state", fsm_state, ST_IDLE);

    // first-request latency: start is high in the cycle after push edge + 2
    send(8'd3, 8'd4, 1'b1);
    check("lat_cycle0", line_start, 0);
    @(negedge clk);
    check("lat_cycle1", line_start, 0);
    @(negedge clk);
    check("lat_cycle2", line_start, 1);
    check("lat_state", fsm_state, ST_WAIT);
    wait_idle(200);
    drain();

    // vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].x, tbl[i].y, tbl[i].pen);
      wait_idle(200);
      check($sformatf("tbl%0d_req_count", i), start_cnt - rd, tbl[i].exp_req);
      if (tbl[i].exp_req != 0 && start_cnt > rd && start_cnt <= OBS_N)
        check($sformatf("tbl%0d_line", i), obs[start_cnt-1], tbl[i].exp_line);
      rd = start_cnt;
    end

    // backpressure with a slow engine
    do_reset();
    eng_delay = 50;
    send(8'd11, 8'd1, 1'b1);
    send(8'd22, 8'd2, 1'b1);
    send(8'd33, 8'd3, 1'b1);
    send(8'd44, 8'd4, 1'b1);
    check("bp_ready_at_3", point_ready, 1);
    send(8'd55, 8'd5, 1'b1);
    check("bp_ready_at_4", point_ready, 0);
    send(8'd66, 8'd6, 1'b1);
    wait_idle(2000);
    drain();

    // watchdog abort, then a fresh dot
    do_reset();
    eng_delay = 3;
    eng_hang  = 1'b1;
    send(8'd50, 8'd60, 1'b1);
    n = 0;
    while (!line_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wd_start_latency", n, 2);
    m = 0;
    while (!line_abort && m < 1000) begin
      @(negedge clk);
      m++;
    end
    check("wd_abort_delay", m, TIMEOUT);
    check("wd_timeout_err", timeout_err, 1);
    @(negedge clk);
    check("wd_abort_pulse", line_abort, 0);
    check("wd_err_pulse", timeout_err, 0);
    check("wd_state", fsm_state, ST_IDLE);
    drain();
    m_lv     = 1'b0;
    eng_hang = 1'b0;
    send(8'd1, 8'd1, 1'b1);
    wait_idle(200);
    drain();

    // reset during WAIT with queued points, then a late done
    eng_hang = 1'b1;
    send(8'd8, 8'd9, 1'b1);
    send(8'd11, 8'd12, 1'b1);
    send(8'd13, 8'd14, 1'b1);
    repeat (5) @(negedge clk);
    check("mid_state_wait", fsm_state, ST_WAIT);
    do_reset();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", point_ready, 1);
    check("mid_rst_coords", cur_line, 0);
    check("mid_rst_state", fsm_state, ST_IDLE);
    eng_hang = 1'b0;
    inject_req++;
    repeat (10) @(negedge clk);
    check("late_done_no_req", start_cnt - rd, 0);
    check("late_done_state", fsm_state, ST_IDLE);
    check("late_done_busy", busy, 0);
    send(8'd2, 8'd3, 1'b1);
    wait_idle(200);
    drain();

    // randomized point stream against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      eng_delay = $urandom_range(1, 8);
      send(CW'($urandom_range(0, 3)), CW'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(5000);
    drain();
    check("no_overlapping_starts", overlap_err, 0);
    check("coords_held_stable", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : guard
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/stroke_sequencer.md
Name: stroke_sequencer

Overview:
- Initiator side of the line-engine start/done interface.
- Accepts a stream of tracked pen points from the position tracker and buffers them in a small FIFO.
- For each pen-down point it issues one line request to the line engine, from the previous point to the new point, then waits for the engine's done.
- Sits between the tracker and the line engine. It owns sequencing, pen-up handling and hang recovery.

Parameters:
- CW, 8, coordinate width in bits. It must match the line engine.
- DEPTH, 4, point FIFO depth. Must be a power of two, at least 2.
- TIMEOUT, 600, maximum cycles WAIT may last before the request is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- point_valid  in  1  tracker offers a point.
- point_ready  out  1  FIFO can accept a point. Equals not-full.
- point_x  in  CW  point x coordinate.
- point_y  in  CW  point y coordinate.
- point_pen  in  1  1 = pen down at this point, 0 = pen up.
- line_start  out  1  one-cycle request pulse to the line engine.
- line_x0, line_y0, line_x1, line_y1  out  CW each  line endpoints. Held stable from the start pulse until done or abort.
- line_done  in  1  engine completion pulse.
- line_abort  out  1  one-cycle pulse to reset a hung engine. Wired OR-ed into the engine reset.
- busy  out  1  high in ISSUE or WAIT, or when the FIFO is non-empty.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (synchronous, active-high): FIFO emptied; last_valid=0; state IDLE.
- Output reset values: line_start=0, line_abort=0, timeout_err=0, busy=0, point_ready=1. line_* coordinates=0.
- Reset mid-operation discards any queued points and the in-flight request. No done is awaited.
- FIFO push: on point_valid && point_ready.
- FIFO pop and push in the same cycle: allowed, count unchanged.
- Push when full: impossible, because point_ready=0.
- point_ready is derived combinationally from the count register.
- Registers: last_x, last_y, last_valid. last_valid means the previous point was pen-down and has been drawn.
- State machine, state IDLE, when the FIFO is non-empty:
  - Pop the head entry.
  - pen=0: set last_valid=0 and stay in IDLE. No request is issued.
  - pen=1 and last_valid=0: load x0=x1=pt.x and y0=y1=pt.y (single-pixel dot). Go to ISSUE.
  - pen=1 and last_valid=1 and pt equals (last_x,last_y): drop the point and stay in IDLE.
  - pen=1, otherwise: load x0=last_x, y0=last_y, x1=pt.x, y1=pt.y. Go to ISSUE.
- State ISSUE: line_start=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- State WAIT:
  - line_start=0.
  - Watchdog increments every cycle.
  - On line_done: set last_x=line_x1, last_y=line_y1, last_valid=1. Go to IDLE.
  - If the watchdog reaches TIMEOUT-1 without done: pulse line_abort and timeout_err (1 cycle), set last_valid=0, go to IDLE.
  - If done and timeout occur in the same cycle, done wins.
- line_done seen in IDLE or ISSUE is ignored.
- Latency: for a point accepted at edge T with an empty FIFO and state IDLE, the pop occurs at edge T+1 and line_start is high during the cycle after edge T+2.
- Throughput: at most one request per engine completion, plus 2 cycles overhead.
- Coordinates are unsigned CW-bit values passed through unchanged, with no arithmetic on them. Equality compares are full-width.
- The watchdog counter is $clog2(TIMEOUT)+1 bits and saturates. It never wraps.

Decomposition:
- Shared package holds:
  - CW default
  - the point record (x, y, pen)
  - state encoding IDLE/ISSUE/WAIT
  - the DEPTH default shared with the tracker
- One sub-module, point_fifo: synchronous FIFO with parameters WIDTH=2*CW+1 and DEPTH.
  - Pointers wrap modulo DEPTH.
  - Count register runs 0..DEPTH.
  - Outputs full, empty and head.
- The sequencer FSM and watchdog stay in stroke_sequencer.

Test Plan:
- Single dot: reset, then push (10,20,pen=1) with an engine model that returns done 3 cycles after start. Required: one line_start with x0=x1=10, y0=y1=20. Afterwards last_valid=1 and busy falls after done.
- Polyline: push (10,20,1), (30,25,1), (30,60,1). Required: three requests, (10,20)->(10,20), then (10,20)->(30,25), then (30,25)->(30,60). Each start comes only after the previous done.
- Pen-up break: push (5,5,1), (9,9,0), (40,40,1). Required: exactly two requests, dot (5,5) and dot (40,40). No line from (5,5) to (40,40).
- FIFO full/backpressure: engine holds done off for 50 cycles, and 6 points are offered back-to-back. Required: point_ready drops after the FIFO holds 4. No point is lost or duplicated. Requests come in order. Same-cycle push/pop keeps the count.
- Duplicate point: push (7,7,1) twice. Required: a single request only.
- Watchdog and reset: engine never asserts done, with TIMEOUT=600. Required: line_abort and timeout_err pulse exactly 600 cycles after start. Then push (1,1,1), which yields a dot request. Separately, asserting reset during WAIT clears everything, and a late done is ignored.
